// File: rtl/fp_div.sv
// Iterative IEEE-754 divider: unpack, normalize denormals, restoring
// division one quotient bit per cycle, then round-to-nearest-even and pack.
// Special operands skip straight to the commit stage (ROUND).
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// UNPACK | classify latched operands, build significands and exponents
// NORM   | shift a denormal significand left, a first, then b
// DIV    | restoring division, one quotient bit per cycle
// ROUND  | align, round, pack and commit q/flags with a done pulse
module fp_div #(
  parameter int NEXP = 11,
  parameter int NSIG = 52,
  localparam int W = NEXP + NSIG + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic         nan,
  output logic         inf,
  output logic         zero,
  output logic         dnorm,
  output logic         norm,
  output logic         dbz
);

  localparam int M  = NSIG + 1;   // significand with hidden bit
  localparam int K  = NSIG + 3;   // quotient bits: significand, guard, round
  localparam int EW = NEXP + 3;   // signed working exponent
  localparam int CW = $clog2(K);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (NEXP - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << NEXP) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, NORM, DIV, ROUND} state_t;

  state_t                 state;
  logic [W-1:0]           ar, br;
  logic [M-1:0]           ma, mb;
  logic signed [EW-1:0]   xa, xb;
  logic [M:0]             rem;
  logic [K-1:0]           qw;
  logic [CW-1:0]          cnt;
  logic                   sgn;
  logic                   sp;
  logic [W-1:0]           sp_q;
  logic                   sp_dbz;

  // class of a stored word (sign excluded): {nan, inf, zero, dnorm, norm}
  function automatic logic [4:0] cls(input logic [W-2:0] v);
    logic emx, ez, fz;
    emx = &v[W-2:NSIG];
    ez  = ~|v[W-2:NSIG];
    fz  = ~|v[NSIG-1:0];
    cls = {emx & ~fz, emx & fz, ez & fz, ez & ~fz, ~emx & ~ez};
  endfunction

  // operand field decode from the latched operands
  logic [NEXP-1:0]      a_e, b_e;
  logic [NSIG-1:0]      a_f, b_f;
  logic                 a_ez, b_ez, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [M-1:0]         ua_m, ub_m;
  logic signed [EW-1:0] ua_x, ub_x;
  logic                 s_ab;

  assign a_e    = ar[W-2:NSIG];
  assign b_e    = br[W-2:NSIG];
  assign a_f    = ar[NSIG-1:0];
  assign b_f    = br[NSIG-1:0];
  assign a_ez   = ~|a_e;
  assign b_ez   = ~|b_e;
  assign a_nan  = (&a_e) & (|a_f);
  assign b_nan  = (&b_e) & (|b_f);
  assign a_inf  = (&a_e) & ~(|a_f);
  assign b_inf  = (&b_e) & ~(|b_f);
  assign a_zero = a_ez & ~(|a_f);
  assign b_zero = b_ez & ~(|b_f);
  assign ua_m   = {~a_ez, a_f};
  assign ub_m   = {~b_ez, b_f};
  // a denormal carries the same scale as exponent field 1
  assign ua_x   = a_ez ? EW'(1) : {3'b000, a_e};
  assign ub_x   = b_ez ? EW'(1) : {3'b000, b_e};
  assign s_ab   = ar[W-1] ^ br[W-1];

  // special-operand result selection
  logic         sp_hit, sp_dz;
  logic [W-1:0] sp_val;
  always_comb begin
    sp_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    sp_dz  = 1'b0;
    if (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) begin
      sp_val = QNAN;
    end else if (a_inf) begin
      sp_val = {s_ab, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end else if (b_inf | a_zero) begin
      sp_val = {s_ab, {(W-1){1'b0}}};
    end else begin
      sp_val = {s_ab, {NEXP{1'b1}}, {NSIG{1'b0}}};
      sp_dz  = 1'b1;
    end
  end

  // one normalizing shift: a first, then b
  logic [M-1:0]         na_m, nb_m;
  logic signed [EW-1:0] na_x, nb_x;
  always_comb begin
    na_m = ma;
    na_x = xa;
    nb_m = mb;
    nb_x = xb;
    if (!ma[M-1]) begin
      na_m = {ma[M-2:0], 1'b0};
      na_x = xa - EW'(1);
    end else if (!mb[M-1]) begin
      nb_m = {mb[M-2:0], 1'b0};
      nb_x = xb - EW'(1);
    end
  end

  // restoring division step
  logic       rem_ge;
  logic [M:0] rem_sub;
  always_comb begin
    rem_ge  = rem >= {1'b0, mb};
    rem_sub = rem_ge ? (rem - {1'b0, mb}) : rem;
  end

  // quotient alignment, denormal shift, rounding and packing
  logic signed [EW-1:0] e0, e1, ebase, e_out, cy;
  logic [EW-1:0]        shu;
  logic [K-1:0]         xs, xsh;
  logic [M-1:0]         sig;
  logic [M:0]           sig_r;
  logic                 dn, lost, g, stk, up;
  logic [W-1:0]         res, nxt_q;
  always_comb begin
    e0 = xa - xb + BIAS;
    if (qw[K-1]) begin
      xs = qw;
      e1 = e0;
    end else begin
      xs = {qw[K-2:0], 1'b0};
      e1 = e0 - EW'(1);
    end
    dn    = 1'b0;
    lost  = 1'b0;
    xsh   = xs;
    ebase = e1;
    shu   = '0;
    if (e1[EW-1] || (e1 == '0)) begin
      dn    = 1'b1;
      ebase = '0;
      shu   = EW'(1) - e1;
      if (shu >= EW'(K)) begin
        xsh  = '0;
        lost = |xs;
      end else begin
        xsh  = xs >> shu;
        lost = |(xs & ~({K{1'b1}} << shu));
      end
    end
    sig   = xsh[K-1:2];
    g     = xsh[1];
    stk   = xsh[0] | lost | (|rem);
    up    = g & (stk | sig[0]);
    sig_r = {1'b0, sig} + {{M{1'b0}}, up};
    // carry into the hidden bit (denormal) or past it (normal) bumps exponent
    cy    = '0;
    cy[0] = dn ? sig_r[M-1] : sig_r[M];
    e_out = ebase + cy;
    if (e_out >= EMAX) res = {sgn, {NEXP{1'b1}}, {NSIG{1'b0}}};
    else               res = {sgn, e_out[NEXP-1:0], sig_r[NSIG-1:0]};
    nxt_q = sp ? sp_q : res;
  end

  // control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      q      <= '0;
      dbz    <= 1'b0;
      {nan, inf, zero, dnorm, norm} <= 5'b00100;
      ar     <= '0;
      br     <= '0;
      ma     <= '0;
      mb     <= '0;
      xa     <= '0;
      xb     <= '0;
      rem    <= '0;
      qw     <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      sp     <= 1'b0;
      sp_q   <= '0;
      sp_dbz <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ar    <= a;
            br    <= b;
            busy  <= 1'b1;
            dbz   <= 1'b0;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          ma     <= ua_m;
          mb     <= ub_m;
          xa     <= ua_x;
          xb     <= ub_x;
          sgn    <= s_ab;
          sp     <= sp_hit;
          sp_q   <= sp_val;
          sp_dbz <= sp_hit & sp_dz;
          if (sp_hit) begin
            state <= ROUND;
          end else if (!ua_m[M-1] || !ub_m[M-1]) begin
            state <= NORM;
          end else begin
            rem   <= {1'b0, ua_m};
            cnt   <= CW'(K - 1);
            state <= DIV;
          end
        end
        NORM: begin
          ma <= na_m;
          mb <= nb_m;
          xa <= na_x;
          xb <= nb_x;
          if (na_m[M-1] && nb_m[M-1]) begin
            rem   <= {1'b0, na_m};
            cnt   <= CW'(K - 1);
            state <= DIV;
          end
        end
        DIV: begin
          rem <= {rem_sub[M-1:0], 1'b0};
          qw  <= {qw[K-2:0], rem_ge};
          if (cnt == '0) state <= ROUND;
          else           cnt   <= cnt - 1'b1;
        end
        ROUND: begin
          q     <= nxt_q;
          {nan, inf, zero, dnorm, norm} <= cls(nxt_q[W-2:0]);
          dbz   <= sp_dbz;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Directed-vector bench for fp_div in double precision.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] a, b, q;
  logic        busy, done, nan, inf, zero, dnorm, norm, dbz;

  localparam logic [4:0] C_NAN  = 5'b10000;
  localparam logic [4:0] C_INF  = 5'b01000;
  localparam logic [4:0] C_ZERO = 5'b00100;
  localparam logic [4:0] C_DN   = 5'b00010;
  localparam logic [4:0] C_NORM = 5'b00001;

  always #5 clk = ~clk;

  fp_div #(.NEXP(11), .NSIG(52)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q),
    .nan(nan), .inf(inf), .zero(zero), .dnorm(dnorm), .norm(norm),
    .dbz(dbz)
  );

  typedef struct {
    logic [63:0] va;
    logic [63:0] vb;
    logic [63:0] eq;
    logic [4:0]  ecls;
    logic        edbz;
    int          elat;
  } vec_t;

  vec_t vt[18];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // start one operation and count edges from the start edge to done
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, output int lat);
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int lat, dcnt;

    vt[0]  = '{64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, C_NORM, 1'b0, 57};
    vt[1]  = '{64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, C_NORM, 1'b0, 57};
    vt[2]  = '{64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, C_INF,  1'b1, 2};
    vt[3]  = '{64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, C_NAN,  1'b0, 2};
    vt[4]  = '{64'h0000000000000001, 64'h4000000000000000, 64'h0000000000000000, C_ZERO, 1'b0, 109};
    vt[5]  = '{64'h000FFFFFFFFFFFFF, 64'h3FF0000000000000, 64'h000FFFFFFFFFFFFF, C_DN,   1'b0, 58};
    vt[6]  = '{64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, C_INF,  1'b0, 57};
    vt[7]  = '{64'hC000000000000000, 64'h4000000000000000, 64'hBFF0000000000000, C_NORM, 1'b0, 57};
    vt[8]  = '{64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, C_INF,  1'b0, 2};
    vt[9]  = '{64'h3FF0000000000000, 64'h7FF0000000000000, 64'h0000000000000000, C_ZERO, 1'b0, 2};
    vt[10] = '{64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, C_NAN,  1'b0, 2};
    vt[11] = '{64'h7FF0000000000001, 64'h0000000000000000, 64'h7FF8000000000000, C_NAN,  1'b0, 2};
    vt[12] = '{64'h8000000000000000, 64'h4000000000000000, 64'h8000000000000000, C_ZERO, 1'b0, 2};
    vt[13] = '{64'h3FF0000000000000, 64'h8000000000000000, 64'hFFF0000000000000, C_INF,  1'b1, 2};
    vt[14] = '{64'h0000000000000003, 64'h4000000000000000, 64'h0000000000000002, C_DN,   1'b0, 108};
    vt[15] = '{64'h001FFFFFFFFFFFFF, 64'h4000000000000000, 64'h0010000000000000, C_NORM, 1'b0, 57};
    vt[16] = '{64'h3FF0000000000000, 64'h0008000000000000, 64'h7FE0000000000000, C_NORM, 1'b0, 58};
    vt[17] = '{64'h4014000000000000, 64'h4008000000000000, 64'h3FFAAAAAAAAAAAAB, C_NORM, 1'b0, 57};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_q", q, 64'd0);
    chk("reset_dbz", 64'(dbz), 64'd0);
    chk("reset_class", 64'({nan, inf, zero, dnorm, norm}), 64'(C_ZERO));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(vt[i].va, vt[i].vb, lat);
      chk($sformatf("v%0d_q", i), q, vt[i].eq);
      chk($sformatf("v%0d_class", i), 64'({nan, inf, zero, dnorm, norm}), 64'(vt[i].ecls));
      chk($sformatf("v%0d_dbz", i), 64'(dbz), 64'(vt[i].edbz));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].elat));
      chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // reset in the middle of a division
    @(negedge clk);
    a = 64'h4018000000000000; b = 64'h4000000000000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_q", q, 64'd0);
    chk("abort_zero", 64'(zero), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    run_op(64'h3FF0000000000000, 64'h4008000000000000, lat);
    chk("after_abort_q", q, 64'h3FD5555555555555);
    chk("after_abort_latency", 64'(lat), 64'd57);

    // start pulsed while busy is ignored
    @(negedge clk);
    a = 64'h4014000000000000; b = 64'h4008000000000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat == 10) begin
        a = 64'h0; b = 64'h0; start = 1'b1;
      end else if (lat == 11) begin
        start = 1'b0;
      end
    end
    if (!done) lat = -1;
    chk("busy_start_q", q, 64'h3FFAAAAAAAAAAAAB);
    chk("busy_start_latency", 64'(lat), 64'd57);
    chk("busy_start_class", 64'({nan, inf, zero, dnorm, norm}), 64'(C_NORM));

    // back-to-back start in the done cycle; dbz clears on acceptance
    run_op(64'h3FF0000000000000, 64'h0000000000000000, lat);
    chk("b2b_first_dbz", 64'(dbz), 64'd1);
    a = 64'h4018000000000000; b = 64'h4000000000000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_dbz_clear", 64'(dbz), 64'd0);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
    chk("b2b_latency", 64'(lat), 64'd57);
    chk("b2b_q", q, 64'h4008000000000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
